// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, memory,
// ALU, branch and jump steps, decoding the datapath controls from the current state.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_JAL     = 4'd12;
    localparam logic [3:0] S_JR      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [2:0] alu_fn_q;
    logic [2:0] alu_fn_d;
    logic       pc_write_s;
    logic       branch_s;

    // Map an R-type Funct onto its ALU operation; 3'b011 flags an unsupported Funct.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
        logic [2:0] res;
        case (fn)
            6'b100000: res = 3'b010;
            6'b100010: res = 3'b110;
            6'b100100: res = 3'b000;
            6'b100101: res = 3'b001;
            6'b101010: res = 3'b111;
            default:   res = 3'b011;
        endcase
        return res;
    endfunction

    // State and latched ALU function register; reset forces FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            alu_fn_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            alu_fn_q <= alu_fn_d;
        end
    end

    // Next-state logic; Op/Funct are only consulted in DECODE and MEMADR.
    always_comb begin
        state_d  = S_FETCH;
        alu_fn_d = alu_fn_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // EXECUTE uses this captured value so later Funct changes are ignored.
                alu_fn_d = funct_to_alu(Funct);
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (Funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (funct_to_alu(Funct) != 3'b011) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    OP_JAL:  state_d = S_JAL;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_SW) begin
                    state_d = S_MEMWR;
                end else if (Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; unused codes drive the inert defaults.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        RegWrite   = 1'b0;
        pc_write_s = 1'b0;
        branch_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                pc_write_s = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_fn_q;
            end
            S_ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                branch_s   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
            end
            S_JAL: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                RegWrite   = 1'b1;
            end
            S_JR: begin
                PCSrc      = 2'b11;
                pc_write_s = 1'b1;
            end
            default: begin
                IorD = 1'b0;
            end
        endcase
    end

    assign PCEn  = pc_write_s | (branch_s & Zero);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// state by state against hand-written control vectors.
module tb_multicycle_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCEn;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic [3:0] state;

    int total_cnt;
    int bad_cnt;

    logic [16:0] ctl_obs;
    logic [16:0] c_fetch, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
    logic [16:0] c_alu_wb, c_addiex, c_addiwb, c_jump, c_jal, c_jr;

    multicycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .state      (state)
    );

    assign ctl_obs = {IorD, MemWrite, IRWrite, PCEn, ALUSrcA, ALUSrcB, ALUControl,
                      PCSrc, RegDst, MemtoReg, RegWrite};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] cv(input logic iord, input logic mw, input logic irw,
                                       input logic pcen, input logic srca,
                                       input logic [1:0] srcb, input logic [2:0] aluc,
                                       input logic [1:0] pcsrc, input logic [1:0] regdst,
                                       input logic [1:0] m2r, input logic rw);
        return {iord, mw, irw, pcen, srca, srcb, aluc, pcsrc, regdst, m2r, rw};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (obs !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Check the current state and control vector, then advance to the next negedge.
    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] ctl);
        check({tag, ".state"}, {28'd0, state}, {28'd0, st});
        check({tag, ".ctl"}, {15'd0, ctl_obs}, {15'd0, ctl});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        c_fetch  = cv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        c_decode = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        c_memadr = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        c_memrd  = cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        c_memwb  = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b01, 1'b1);
        c_memwr  = cv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        c_alu_wb = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 2'b01, 2'b00, 1'b1);
        c_addiex = c_memadr;
        c_addiwb = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1);
        c_jump   = cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b10, 2'b00, 2'b00, 1'b0);
        c_jal    = cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b10, 2'b10, 2'b10, 1'b1);
        c_jr     = cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b11, 2'b00, 2'b00, 1'b0);

        reset = 1'b1;
        Op    = 6'b000000;
        Funct = 6'b000000;
        Zero  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.state", {28'd0, state}, 32'd0);
        check("rst.ctl", {15'd0, ctl_obs}, {15'd0, c_fetch});
        reset = 1'b0;

        // lw, with Op scrambled after MEMADR to show it is no longer sampled
        Op = 6'b100011;
        step("lw.f", 4'd0, c_fetch);
        step("lw.d", 4'd1, c_decode);
        step("lw.ma", 4'd2, c_memadr);
        Op = 6'b111111;
        step("lw.rd", 4'd3, c_memrd);
        step("lw.wb", 4'd4, c_memwb);

        Op = 6'b101011;
        step("sw.f", 4'd0, c_fetch);
        step("sw.d", 4'd1, c_decode);
        step("sw.ma", 4'd2, c_memadr);
        step("sw.wr", 4'd5, c_memwr);

        // slt, then Funct changed to add after DECODE: EXECUTE must keep slt
        Op = 6'b000000; Funct = 6'b101010;
        step("slt.f", 4'd0, c_fetch);
        step("slt.d", 4'd1, c_decode);
        Funct = 6'b100000;
        step("slt.ex", 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0));
        step("slt.wb", 4'd7, c_alu_wb);

        Funct = 6'b100010;
        step("sub.f", 4'd0, c_fetch);
        step("sub.d", 4'd1, c_decode);
        step("sub.ex", 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b00, 2'b00, 2'b00, 1'b0));
        step("sub.wb", 4'd7, c_alu_wb);

        Funct = 6'b100101;
        step("or.f", 4'd0, c_fetch);
        step("or.d", 4'd1, c_decode);
        step("or.ex", 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0));
        step("or.wb", 4'd7, c_alu_wb);

        Op = 6'b001000;
        step("addi.f", 4'd0, c_fetch);
        step("addi.d", 4'd1, c_decode);
        step("addi.ex", 4'd9, c_addiex);
        step("addi.wb", 4'd10, c_addiwb);

        Op = 6'b000100; Zero = 1'b1;
        step("beqt.f", 4'd0, c_fetch);
        step("beqt.d", 4'd1, c_decode);
        step("beqt.br", 4'd8, cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b110, 2'b01, 2'b00, 2'b00, 1'b0));
        Zero = 1'b0;
        step("beqn.f", 4'd0, c_fetch);
        step("beqn.d", 4'd1, c_decode);
        step("beqn.br", 4'd8, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, 2'b00, 2'b00, 1'b0));

        Op = 6'b000010;
        step("j.f", 4'd0, c_fetch);
        step("j.d", 4'd1, c_decode);
        step("j.j", 4'd11, c_jump);

        Op = 6'b000011;
        step("jal.f", 4'd0, c_fetch);
        step("jal.d", 4'd1, c_decode);
        step("jal.jal", 4'd12, c_jal);

        Op = 6'b000000; Funct = 6'b001000;
        step("jr.f", 4'd0, c_fetch);
        step("jr.d", 4'd1, c_decode);
        step("jr.jr", 4'd13, c_jr);

        Op = 6'b111111;
        step("bad.f", 4'd0, c_fetch);
        step("bad.d", 4'd1, c_decode);
        Op = 6'b000000; Funct = 6'b111111;
        step("badfn.f", 4'd0, c_fetch);
        step("badfn.d", 4'd1, c_decode);

        // sw aborted by reset between clock edges while in MEMWR
        Op = 6'b101011;
        step("swr.f", 4'd0, c_fetch);
        step("swr.d", 4'd1, c_decode);
        step("swr.ma", 4'd2, c_memadr);
        check("swr.wr.mw", {31'd0, MemWrite}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("swr.abort.state", {28'd0, state}, 32'd0);
        check("swr.abort.mw", {31'd0, MemWrite}, 32'd0);
        check("swr.abort.ctl", {15'd0, ctl_obs}, {15'd0, c_fetch});
        @(negedge clk);
        check("swr.hold.state", {28'd0, state}, 32'd0);
        reset = 1'b0;
        Op = 6'b000010;
        step("post.f", 4'd0, c_fetch);
        step("post.d", 4'd1, c_decode);
        step("post.j", 4'd11, c_jump);
        step("post.f2", 4'd0, c_fetch);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one clock and one reset: clk is the single clock; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  instruction[31:26] from the instruction register.
- Funct  in  6  instruction[5:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  unified memory write enable.
- IRWrite  out  1  instruction register load enable.
- PCEn  out  1  PC register load enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=register A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10={PC[31:28],instr[25:0],00}, 11=register A.
- RegDst  out  2  write-register select: 00=rt, 01=rd, 10=r31.
- MemtoReg  out  2  write-data select: 00=ALUOut, 01=Data register, 10=PC.
- RegWrite  out  1  register file write enable.
- state  out  4  current FSM state, for debug and verification.

Function
REQ-003 The block SHALL be a Moore FSM; exceptions: PCEn = PCWrite | (Branch & Zero), and ALUControl in EXECUTE decodes Funct.
REQ-004 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, JR 13; codes 14 and 15 go to FETCH.
REQ-005 Default output values SHALL be 0, with ALUControl=010; each state drives only the listed deviations.
REQ-006 FETCH SHALL drive IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, PCWrite=1 (PCEn=1); next state DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut), and SHALL branch on Op:
- 100011 lw or 101011 sw -> MEMADR.
- 000000 with Funct 001000 (jr) -> JR.
- 000000 with Funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE.
- 000100 beq -> BRANCH.
- 001000 addi -> ADDIEX.
- 000010 j -> JUMP.
- 000011 jal -> JAL.
- any other Op or Funct -> FETCH, with no register or memory write.
REQ-008 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10; next state MEMRD for lw, MEMWR for sw.
REQ-009 MEMRD SHALL drive IorD=1; next state MEMWB.
REQ-010 MEMWB SHALL drive RegDst=00, MemtoReg=01, RegWrite=1; next state FETCH.
REQ-011 MEMWR SHALL drive IorD=1, MemWrite=1; next state FETCH.
REQ-012 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, and ALUControl from Funct (add 010, sub 110, and 000, or 001, slt 111); next state ALUWB.
REQ-013 ALUWB SHALL drive RegDst=01, MemtoReg=00, RegWrite=1; next state FETCH.
REQ-014 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1, so PCEn=Zero; next state FETCH.
REQ-015 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10; next state ADDIWB.
REQ-016 ADDIWB SHALL drive RegDst=00, MemtoReg=00, RegWrite=1; next state FETCH.
REQ-017 JUMP SHALL drive PCSrc=10, PCWrite=1; next state FETCH.
REQ-018 JAL SHALL drive PCSrc=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1, so r31 captures PC+4 on the same edge as the PC update; next state FETCH.
REQ-019 JR SHALL drive PCSrc=11, PCWrite=1; next state FETCH.
REQ-020 Instruction latency, counted from entry into FETCH, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3, jr 3; unsupported 2.
REQ-021 MemWrite, RegWrite and IRWrite SHALL never be asserted in the same cycle as one another.
REQ-022 The block SHALL sample Op and Funct only in DECODE and MEMADR; input changes in other states SHALL have no effect.

Reset
REQ-023 While reset=1, state SHALL be FETCH (0) asynchronously, and the outputs SHALL equal the FETCH decode of REQ-006.
REQ-024 Reset asserted mid-instruction SHALL abort it immediately: no further MemWrite or RegWrite pulse; FETCH resumes on the first clk edge after reset deasserts.

Verification
REQ-025 lw (Op=100011): state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=01, RegDst=00.
REQ-026 beq with Zero=1 then Zero=0: PCEn=1 in BRANCH for the first, PCEn=0 for the second; ALUControl=110 in both.
REQ-027 R-type Funct=101010: EXECUTE drives ALUControl=111; ALUWB drives RegWrite=1, RegDst=01; 4 cycles total.
REQ-028 jal: state 12 drives PCEn=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1; jr (Funct=001000): state 13 drives PCSrc=11.
REQ-029 Op=111111: state sequence 0,1,0; MemWrite and RegWrite stay 0 throughout.
REQ-030 Reset asserted during MEMWR between clock edges: MemWrite falls to 0 and state reads 0 without a clock edge.
